reorder_buffer: RTL
===================

// Module: reorder_buffer
// PURPOSE
// Circular in-order retirement queue downstream of the reservation station and load/store buffer.
// Allocates one entry per issued instruction and returns its ROB index as the dependency tag.
// Captures result broadcasts from the RS and LSB buses and retires the head entry in program order:
// register writes, store release, branch resolution. A mispredicted branch at the head flushes the pipeline.
// PARAMETERS
// ROB_WIDTH  4  log2 entry count (SIZE = 2**ROB_WIDTH = 16)
// PORTS
// clockIn         in   1          clock, posedge
// resetIn         in   1          reset, synchronous, active-low
// readyIn         in   1          global enable; low = freeze
// issueValid      in   1          allocate entry this cycle
// issueType       in   2          00 REG, 01 STORE, 10 BRANCH, 11 reserved (treated as REG)
// issueDest       in   5          rd for REG (x0 = no write)
// issueHasValue   in   1          result already known at issue (LUI/AUIPC/JAL link)
// issueValue      in   32         result when issueHasValue
// issuePredTaken  in   1          BRANCH predicted direction
// issueAltPc      in   32         BRANCH pc to redirect to if mispredicted
// issueRobIndex   out  ROB_WIDTH  index the next issue will take (= tail), combinational
// full            out  1          count >= SIZE-1
// rsUpdate, rsRobIndex[ROB_WIDTH], rsUpdateVal[32]     in  RS result broadcast
// lsbUpdate, lsbRobIndex[ROB_WIDTH], lsbUpdateVal[32]  in  LSB result broadcast
// queryIndex1/2   in   ROB_WIDTH  operand lookup for decoder
// queryReady1/2   out  1          entry valid and result present, combinational
// queryVal1/2     out  32         entry result, combinational
// regWrite        out  1          commit pulse for REG with rd != 0
// regIndex        out  5          committed rd
// regVal          out  32         committed value
// commitRobIndex  out  ROB_WIDTH  index of committed entry; lets the regfile clear its tag
// storeCommit     out  1          pulse: LSB may perform store at commitRobIndex
// flush           out  1          pulse: mispredict; all upstream state must clear
// flushPc         out  32         redirect pc, valid with flush
// BEHAVIOUR
// - Reset (resetIn==0 at posedge): head=tail=count=0, all valid/ready cleared. All pulse outputs 0,
//   regIndex/regVal/commitRobIndex/flushPc 0. Reset mid-operation discards every entry.
// - readyIn==0: no state change; pulse outputs drive 0 that cycle.
// - Issue: with issueValid and count<SIZE, at posedge entry[tail] is written with
//   valid=1 and ready=issueHasValue, and tail=tail+1 mod SIZE (wraps 15->0).
//   Issue with count==SIZE is ignored. Upstream must honour full (one-slot slack).
// - Writeback: on rsUpdate or lsbUpdate, if entry[idx] is valid, at posedge set ready=1 and value=val.
//   RS and LSB on different indices: both are applied. On the same index: LSB wins.
//   A write to an invalid entry is ignored.
// - Commit: at most one per cycle, from stored state only. If entry[head] is valid and ready at posedge:
//   head+1, valid cleared, and outputs registered (visible the cycle after):
//     REG:    regWrite = (dest != 0)
//     STORE:  storeCommit = 1
//     BRANCH: mispredict if value[0] != predTaken -> flush = 1, flushPc = altPc
//   commitRobIndex is always updated.
// - Latency: writeback at edge N -> ready at N -> commit at edge N+1 -> outputs high during cycle N+1..N+2.
//   Same-cycle issue and commit: count unchanged.
// - Flush: at the commit edge of a mispredicted branch, all entries are invalidated and head=tail=count=0.
//   Any issue on that edge is dropped.
//   During the cycle flush is high, issue and writebacks are ignored.
// - Query ports read stored arrays only, with no bus bypass. The RS merges broadcasts itself.
// - count is ROB_WIDTH+1 bits wide. Full/empty is derived from count, not head==tail.
// TESTING
// - Reset, then issue REG x5 with issueHasValue=1, val 0x2A -> regWrite, regIndex=5,
//   regVal=0x2A, commitRobIndex=0, exactly 2 cycles after issue.
// - Issue 3 REG entries (idx 0,1,2); RS writes idx2 then idx0, LSB writes idx1 ->
//   commits strictly in order 0,1,2 on consecutive cycles.
// - Issue 15 entries without writeback -> full=1 at count 15. Push to 16, then 17th issue ignored.
//   Drain with wrap-around: tail 15->0 -> issueRobIndex returns to 0.
// - BRANCH predTaken=1, altPc 0x1004; RS writes 0 -> flush=1, flushPc=0x1004 for one cycle;
//   younger entries never commit; next issueRobIndex=0.
// - STORE at head, LSB update idx0 val 0 -> storeCommit=1, regWrite=0.
//   Same-cycle RS and LSB on one index -> LSB value retained.
// - readyIn=0 for 3 cycles with head ready -> no commit; resumes the cycle after readyIn=1.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement queue with result capture, commit and mispredict flush
module reorder_buffer #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 readyIn,
  input  logic                 issueValid,
  input  logic [1:0]           issueType,
  input  logic [4:0]           issueDest,
  input  logic                 issueHasValue,
  input  logic [31:0]          issueValue,
  input  logic                 issuePredTaken,
  input  logic [31:0]          issueAltPc,
  output logic [ROB_WIDTH-1:0] issueRobIndex,
  output logic                 full,
  input  logic                 rsUpdate,
  input  logic [ROB_WIDTH-1:0] rsRobIndex,
  input  logic [31:0]          rsUpdateVal,
  input  logic                 lsbUpdate,
  input  logic [ROB_WIDTH-1:0] lsbRobIndex,
  input  logic [31:0]          lsbUpdateVal,
  input  logic [ROB_WIDTH-1:0] queryIndex1,
  output logic                 queryReady1,
  output logic [31:0]          queryVal1,
  input  logic [ROB_WIDTH-1:0] queryIndex2,
  output logic                 queryReady2,
  output logic [31:0]          queryVal2,
  output logic                 regWrite,
  output logic [4:0]           regIndex,
  output logic [31:0]          regVal,
  output logic [ROB_WIDTH-1:0] commitRobIndex,
  output logic                 storeCommit,
  output logic                 flush,
  output logic [31:0]          flushPc
);
  localparam int SIZE = 2 ** ROB_WIDTH;
  localparam logic [ROB_WIDTH:0] SIZE_C = (ROB_WIDTH + 1)'(SIZE);
  localparam logic [ROB_WIDTH:0] FULL_C = (ROB_WIDTH + 1)'(SIZE - 1);
  typedef enum logic [1:0] {T_REG, T_STORE, T_BRANCH, T_RSVD} rob_type_e;
  logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d, commit_idx_q, commit_idx_d;
  logic [ROB_WIDTH:0]   count_q, count_d;
  logic [SIZE-1:0]      valid_q, valid_d, ready_q, ready_d, pred_q, pred_d;
  rob_type_e            type_q [SIZE];
  rob_type_e            type_d [SIZE];
  logic [4:0]           dest_q [SIZE];
  logic [4:0]           dest_d [SIZE];
  logic [31:0]          value_q [SIZE];
  logic [31:0]          value_d [SIZE];
  logic [31:0]          alt_q [SIZE];
  logic [31:0]          alt_d [SIZE];
  logic                 reg_write_q, reg_write_d, store_commit_q, store_commit_d, flush_q, flush_d;
  logic [4:0]           reg_index_q, reg_index_d;
  logic [31:0]          reg_val_q, reg_val_d, flush_pc_q, flush_pc_d;
  logic                 live, issue_en, commit_en, head_is_reg, mispredict;
  rob_type_e            head_type;
  // Next state: writebacks, then issue, then commit; a mispredict commit wipes everything
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    ready_d = ready_q;
    pred_d = pred_q;
    type_d = type_q;
    dest_d = dest_q;
    value_d = value_q;
    alt_d = alt_q;
    commit_idx_d = commit_idx_q;
    reg_index_d = reg_index_q;
    reg_val_d = reg_val_q;
    flush_pc_d = flush_pc_q;
    reg_write_d = 1'b0;
    store_commit_d = 1'b0;
    flush_d = 1'b0;
    live = readyIn & ~flush_q;
    issue_en = live & issueValid & (count_q < SIZE_C);
    commit_en = readyIn & valid_q[head_q] & ready_q[head_q];
    head_type = type_q[head_q];
    head_is_reg = (head_type != T_STORE) && (head_type != T_BRANCH);
    mispredict = commit_en && (head_type == T_BRANCH) && (value_q[head_q][0] != pred_q[head_q]);
    if (live && rsUpdate && valid_q[rsRobIndex]) begin
      ready_d[rsRobIndex] = 1'b1;
      value_d[rsRobIndex] = rsUpdateVal;
    end
    if (live && lsbUpdate && valid_q[lsbRobIndex]) begin
      ready_d[lsbRobIndex] = 1'b1;
      value_d[lsbRobIndex] = lsbUpdateVal;
    end
    if (issue_en) begin
      valid_d[tail_q] = 1'b1;
      ready_d[tail_q] = issueHasValue;
      type_d[tail_q] = rob_type_e'(issueType);
      dest_d[tail_q] = issueDest;
      value_d[tail_q] = issueValue;
      pred_d[tail_q] = issuePredTaken;
      alt_d[tail_q] = issueAltPc;
      tail_d = tail_q + 1'b1;
    end
    if (commit_en) begin
      valid_d[head_q] = 1'b0;
      head_d = head_q + 1'b1;
      commit_idx_d = head_q;
      reg_write_d = head_is_reg && (dest_q[head_q] != 5'd0);
      reg_index_d = head_is_reg ? dest_q[head_q] : reg_index_q;
      reg_val_d = head_is_reg ? value_q[head_q] : reg_val_q;
      store_commit_d = head_type == T_STORE;
    end
    count_d = count_q + (ROB_WIDTH + 1)'(issue_en) - (ROB_WIDTH + 1)'(commit_en);
    if (mispredict) begin
      flush_d = 1'b1;
      flush_pc_d = alt_q[head_q];
      valid_d = '0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end
  end
  // Control and commit-output registers, cleared by reset
  always_ff @(posedge clockIn) begin
    if (!resetIn) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      valid_q <= '0;
      ready_q <= '0;
      commit_idx_q <= '0;
      reg_write_q <= 1'b0;
      reg_index_q <= '0;
      reg_val_q <= '0;
      store_commit_q <= 1'b0;
      flush_q <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      commit_idx_q <= commit_idx_d;
      reg_write_q <= reg_write_d;
      reg_index_q <= reg_index_d;
      reg_val_q <= reg_val_d;
      store_commit_q <= store_commit_d;
      flush_q <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end
  // Entry payload storage; only meaningful where valid is set, so no reset needed
  always_ff @(posedge clockIn) begin
    pred_q <= pred_d;
    type_q <= type_d;
    dest_q <= dest_d;
    value_q <= value_d;
    alt_q <= alt_d;
  end
  assign issueRobIndex = tail_q;
  assign full = count_q >= FULL_C;
  assign queryReady1 = valid_q[queryIndex1] & ready_q[queryIndex1];
  assign queryVal1 = value_q[queryIndex1];
  assign queryReady2 = valid_q[queryIndex2] & ready_q[queryIndex2];
  assign queryVal2 = value_q[queryIndex2];
  assign regWrite = reg_write_q;
  assign regIndex = reg_index_q;
  assign regVal = reg_val_q;
  assign commitRobIndex = commit_idx_q;
  assign storeCommit = store_commit_q;
  assign flush = flush_q;
  assign flushPc = flush_pc_q;
endmodule
